// File: rtl/jtframe_colmix_pri.sv
// Priority colour mixer: picks the first opaque layer, looks it up in a
// CPU-writable 16-bit palette, scales by global brightness and aligns blanking.
// Three pxl_cen stages: priority select, palette read, decode/scale/blank.
module jtframe_colmix_pri #(
    parameter int unsigned LAYERS = 2,
    parameter int unsigned AW     = 8,
    parameter int unsigned CW     = 4,
    parameter logic [3:0]  TRANSP = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pxl_cen,
    input  logic                 LHBL,
    input  logic                 LVBL,
    output logic                 LHBL_dly,
    output logic                 LVBL_dly,
    input  logic [LAYERS*AW-1:0] lyr_addr,
    input  logic [3:0]           bright,
    input  logic                 pal_cs,
    input  logic                 cpu_rnw,
    input  logic [AW:0]          cpu_addr,
    input  logic [7:0]           cpu_dout,
    output logic [7:0]           pal_dout,
    output logic [CW-1:0]        red,
    output logic [CW-1:0]        green,
    output logic [CW-1:0]        blue
);

    localparam int unsigned Entries = 2 ** AW;
    localparam int unsigned PW      = CW + 5;

    // Palette as two byte lanes; word = {odd, even}. Not cleared by reset.
    logic [7:0] pal_even [Entries];
    logic [7:0] pal_odd  [Entries];

    logic [AW-1:0] sel_addr;
    logic          found;

    logic [AW-1:0] s1_addr_q;
    logic          s1_hb_q, s1_vb_q;
    logic [15:0]   s2_word_q;
    logic          s2_hb_q, s2_vb_q;
    logic [CW-1:0] red_q, green_q, blue_q;
    logic          hb_dly_q, vb_dly_q;
    logic [7:0]    pal_dout_q;

    logic [CW-1:0] dec_r, dec_g, dec_b;

    // (c * (bright+1)) >> 4, keeping CW bits; bright=15 is identity.
    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [3:0] b);
        logic [PW-1:0] prod;
        prod = PW'(c) * PW'({1'b0, b} + 5'd1);
        return prod[CW+3:4];
    endfunction

    // Lowest-index opaque layer wins; the last layer is the fallback backdrop.
    always_comb begin
        sel_addr = lyr_addr[(LAYERS-1)*AW +: AW];
        found    = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            if (!found && lyr_addr[i*AW +: 4] != TRANSP) begin
                sel_addr = lyr_addr[i*AW +: AW];
                found    = 1'b1;
            end
        end
    end

    // CPU writes go straight to the lane, independent of pxl_cen.
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_rnw) begin
            if (cpu_addr[0]) pal_odd[cpu_addr[AW:1]]  <= cpu_dout;
            else             pal_even[cpu_addr[AW:1]] <= cpu_dout;
        end
    end

    // CPU read port: registered lane byte, holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pal_dout_q <= 8'd0;
        end else if (pal_cs && cpu_rnw) begin
            pal_dout_q <= cpu_addr[0] ? pal_odd[cpu_addr[AW:1]] : pal_even[cpu_addr[AW:1]];
        end
    end

    // Stage 1: register the selected palette address and blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_addr_q <= '0;
            s1_hb_q   <= 1'b0;
            s1_vb_q   <= 1'b0;
        end else if (pxl_cen) begin
            s1_addr_q <= sel_addr;
            s1_hb_q   <= LHBL;
            s1_vb_q   <= LVBL;
        end
    end

    // Stage 2: synchronous palette read; a same-clk CPU write is not seen yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_word_q <= 16'd0;
            s2_hb_q   <= 1'b0;
            s2_vb_q   <= 1'b0;
        end else if (pxl_cen) begin
            s2_word_q <= {pal_odd[s1_addr_q], pal_even[s1_addr_q]};
            s2_hb_q   <= s1_hb_q;
            s2_vb_q   <= s1_vb_q;
        end
    end

    if (CW == 5) begin : g_cw5
        // 15-bit RGB, top bit of the word is spare.
        logic unused_msb;
        assign unused_msb = s2_word_q[15];
        assign dec_r = s2_word_q[14:10];
        assign dec_g = s2_word_q[9:5];
        assign dec_b = s2_word_q[4:0];
    end else begin : g_cw4
        // 12-bit RGB in the top three nibbles, low nibble spare.
        logic [3:0] unused_lsb;
        assign unused_lsb = s2_word_q[3:0];
        assign dec_r = s2_word_q[15:12];
        assign dec_g = s2_word_q[11:8];
        assign dec_b = s2_word_q[7:4];
    end

    // Stage 3: brightness scale and blanking, aligned blank outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            hb_dly_q <= 1'b0;
            vb_dly_q <= 1'b0;
        end else if (pxl_cen) begin
            hb_dly_q <= s2_hb_q;
            vb_dly_q <= s2_vb_q;
            if (s2_hb_q && s2_vb_q) begin
                red_q   <= scale(dec_r, bright);
                green_q <= scale(dec_g, bright);
                blue_q  <= scale(dec_b, bright);
            end else begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end
        end
    end

    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = hb_dly_q;
    assign LVBL_dly = vb_dly_q;
    assign pal_dout = pal_dout_q;

endmodule

// File: tb/tb_jtframe_colmix_pri.sv
// Bench for jtframe_colmix_pri: two instances (CW=4 and CW=5, three layers)
// share all inputs; a tick-indexed reference model is compared every clk.
module tb_jtframe_colmix_pri;

    logic        clk;
    logic        rst_n;
    logic        pxl_cen;
    logic        LHBL, LVBL;
    logic [23:0] lyr_addr;
    logic [3:0]  bright;
    logic        pal_cs, cpu_rnw;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout;

    logic       hb4, vb4, hb5, vb5;
    logic [7:0] dout4, dout5;
    logic [3:0] r4, g4, b4;
    logic [4:0] r5, g5, b5;

    jtframe_colmix_pri #(.LAYERS(3), .AW(8), .CW(4), .TRANSP(4'hF)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(hb4), .LVBL_dly(vb4), .lyr_addr(lyr_addr), .bright(bright),
        .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_dout(dout4), .red(r4), .green(g4), .blue(b4)
    );

    jtframe_colmix_pri #(.LAYERS(3), .AW(8), .CW(5), .TRANSP(4'hF)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(hb5), .LVBL_dly(vb5), .lyr_addr(lyr_addr), .bright(bright),
        .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_dout(dout5), .red(r5), .green(g5), .blue(b5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;
    bit checking = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] pal_m   [256];
    logic [7:0]  addr_at [4096];
    bit          lh_at   [4096];
    bit          lv_at   [4096];
    logic [15:0] word_at [4096];
    int t;
    int e4 [3];
    int e5 [3];
    int e_lh, e_lv, e_dout;

    function automatic logic [7:0] pick(input logic [23:0] a);
        if (a[3:0] != 4'hF) return a[7:0];
        else if (a[11:8] != 4'hF) return a[15:8];
        else return a[23:16];
    endfunction

    // Channel idx 0=R,1=G,2=B of a palette word at channel width cw.
    function automatic int chan(input logic [15:0] w, input int cw, input int idx);
        if (cw == 4) return (int'(w) >> (12 - 4 * idx)) & 15;
        else return (int'(w) >> (10 - 5 * idx)) & 31;
    endfunction

    function automatic int scl(input int c, input int b);
        return (c * (b + 1)) / 16;
    endfunction

    // Output after cen tick t shows pixel sampled at t-2, with the palette
    // word as it stood at tick t-1 and the brightness present at tick t.
    initial begin
        t = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0;
                for (int i = 0; i < 3; i++) begin
                    e4[i] = 0;
                    e5[i] = 0;
                end
                e_lh = 0;
                e_lv = 0;
                e_dout = 0;
            end else begin
                if (pal_cs && cpu_rnw)
                    e_dout = cpu_addr[0] ? int'(pal_m[cpu_addr[8:1]][15:8])
                                         : int'(pal_m[cpu_addr[8:1]][7:0]);
                if (pxl_cen && t < 4095) begin
                    addr_at[t] = pick(lyr_addr);
                    lh_at[t] = LHBL;
                    lv_at[t] = LVBL;
                    if (t >= 1) word_at[t] = pal_m[addr_at[t-1]];
                    if (t >= 2) begin
                        e_lh = int'(lh_at[t-2]);
                        e_lv = int'(lv_at[t-2]);
                        for (int i = 0; i < 3; i++) begin
                            if (lh_at[t-2] && lv_at[t-2]) begin
                                e4[i] = scl(chan(word_at[t-1], 4, i), int'(bright));
                                e5[i] = scl(chan(word_at[t-1], 5, i), int'(bright));
                            end else begin
                                e4[i] = 0;
                                e5[i] = 0;
                            end
                        end
                    end
                    t++;
                end
                if (pal_cs && !cpu_rnw) begin
                    if (cpu_addr[0]) pal_m[cpu_addr[8:1]][15:8] = cpu_dout;
                    else             pal_m[cpu_addr[8:1]][7:0]  = cpu_dout;
                end
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("r4", int'(r4), e4[0]);
                chk("g4", int'(g4), e4[1]);
                chk("b4", int'(b4), e4[2]);
                chk("r5", int'(r5), e5[0]);
                chk("g5", int'(g5), e5[1]);
                chk("b5", int'(b5), e5[2]);
                chk("lhbl_dly4", int'(hb4), e_lh);
                chk("lvbl_dly4", int'(vb4), e_lv);
                chk("lhbl_dly5", int'(hb5), e_lh);
                chk("lvbl_dly5", int'(vb5), e_lv);
                chk("pal_dout4", int'(dout4), e_dout);
                chk("pal_dout5", int'(dout5), e_dout);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        pal_cs = 1'b1;
        cpu_rnw = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        cyc();
        pal_cs = 1'b0;
        cpu_rnw = 1'b1;
    endtask

    task automatic rd(input logic [8:0] a);
        pal_cs = 1'b1;
        cpu_rnw = 1'b1;
        cpu_addr = a;
        cyc();
        pal_cs = 1'b0;
    endtask

    // One pixel: a cen clk followed by an idle clk.
    task automatic pix(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                       input logic lh, input logic lv);
        lyr_addr = {a2, a1, a0};
        LHBL = lh;
        LVBL = lv;
        pxl_cen = 1'b1;
        cyc();
        pxl_cen = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        pxl_cen = 1'b0;
        LHBL = 1'b1;
        LVBL = 1'b1;
        lyr_addr = '0;
        bright = 4'd15;
        pal_cs = 1'b0;
        cpu_rnw = 1'b1;
        cpu_addr = '0;
        cpu_dout = '0;
        repeat (3) cyc();
        checking = 1;
        chk("reset_red", int'(r4), 0);
        chk("reset_lhbl", int'(hb4), 0);
        chk("reset_dout", int'(dout4), 0);
        rst_n = 1'b1;
        cyc();

        // Basic lookup: word 5 = A5C0.
        wr(9'd10, 8'hC0);
        wr(9'd11, 8'hA5);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t1_r4", int'(r4), 'hA);
        chk("t1_g4", int'(g4), 'h5);
        chk("t1_b4", int'(b4), 'hC);
        chk("t1_r5", int'(r5), 'h09);
        chk("t1_g5", int'(g5), 'h0E);
        rd(9'd11);
        chk("t1_read", int'(dout4), 'hA5);

        // Priority: transparent layer 0, then all-transparent fallback.
        wr(9'h042, 8'h34);
        wr(9'h043, 8'h12);
        wr(9'h064, 8'h78);
        wr(9'h065, 8'h56);
        wr(9'h07E, 8'hBC);
        wr(9'h07F, 8'h9A);
        pix(8'h0F, 8'h21, 8'h32, 1, 1);
        pix(8'h1F, 8'h2F, 8'h3F, 1, 1);
        pix(8'h0F, 8'h2F, 8'h32, 1, 1);
        chk("t2_r4", int'(r4), 1);
        chk("t2_g4", int'(g4), 2);
        chk("t2_b4", int'(b4), 3);
        chk("t2_r5", int'(r5), 4);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t2_fallback_r4", int'(r4), 'h9);
        chk("t2_fallback_b4", int'(b4), 'hB);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t2_l2_g4", int'(g4), 'h6);

        // Brightness on an all-ones word.
        wr(9'h080, 8'hFF);
        wr(9'h081, 8'hFF);
        bright = 4'd7;
        pix(8'h40, 8'h00, 8'h00, 1, 1);
        pix(8'h40, 8'h00, 8'h00, 1, 1);
        pix(8'h40, 8'h00, 8'h00, 1, 1);
        chk("t3_r5_b7", int'(r5), 15);
        chk("t3_b5_b7", int'(b5), 15);
        chk("t3_r4_b7", int'(r4), 7);
        bright = 4'd15;
        pix(8'h40, 8'h00, 8'h00, 1, 1);
        chk("t3_r5_b15", int'(r5), 31);
        chk("t3_r4_b15", int'(r4), 15);
        bright = 4'd0;
        pix(8'h40, 8'h00, 8'h00, 1, 1);
        chk("t3_r5_b0", int'(r5), 1);
        chk("t3_r4_b0", int'(r4), 0);
        bright = 4'd15;

        // CPU write to word 7 in the same clk as its video lookup.
        wr(9'd14, 8'h10);
        wr(9'd15, 8'h11);
        pix(8'h07, 8'h00, 8'h00, 1, 1);
        lyr_addr = {8'h00, 8'h00, 8'h07};
        pxl_cen = 1'b1;
        pal_cs = 1'b1;
        cpu_rnw = 1'b0;
        cpu_addr = 9'd15;
        cpu_dout = 8'hF0;
        cyc();
        pxl_cen = 1'b0;
        pal_cs = 1'b0;
        cpu_rnw = 1'b1;
        cyc();
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t4_old_r4", int'(r4), 1);
        chk("t4_old_g4", int'(g4), 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t4_new_r4", int'(r4), 'hF);
        chk("t4_new_g4", int'(g4), 0);
        chk("t4_new_b4", int'(b4), 1);

        // One-tick horizontal blank mid-line.
        pix(8'h05, 8'h00, 8'h00, 0, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t5_lhbl_low", int'(hb4), 0);
        chk("t5_lvbl_high", int'(vb4), 1);
        chk("t5_blank_r4", int'(r4), 0);
        chk("t5_blank_g5", int'(g5), 0);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t5_lhbl_back", int'(hb4), 1);
        chk("t5_r4_back", int'(r4), 'hA);

        // Vertical blank also forces black.
        pix(8'h05, 8'h00, 8'h00, 1, 0);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t5_vblank_r4", int'(r4), 0);

        // Mid-frame reset with colour on screen, palette must survive.
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        rd(9'd11);
        rst_n = 1'b0;
        cyc();
        chk("t6_r4", int'(r4), 0);
        chk("t6_b5", int'(b5), 0);
        chk("t6_lhbl", int'(hb4), 0);
        chk("t6_dout", int'(dout4), 0);
        rst_n = 1'b1;
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t6_still_zero", int'(r4), 0);
        pix(8'h05, 8'h00, 8'h00, 1, 1);
        chk("t6_first_valid", int'(r4), 'hA);
        rd(9'd11);
        chk("t6_keep_hi", int'(dout4), 'hA5);
        rd(9'd10);
        chk("t6_keep_lo", int'(dout5), 'hC0);

        cyc();
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
